// File: rtl/tx_mac_framer_pkg.sv
// Shared constants and types for the transmit MAC framer and its CRC helper.
package tx_mac_framer_pkg;
    localparam int          GMII_DATA_W     = 8;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          PREAMBLE_LEN    = 7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_ABORT,
        ST_DRAIN
    } tx_mac_state_t;
endpackage

// File: rtl/tx_mac_framer_if.sv
// Byte-stream handshake feeding the framer: source drives data/valid/last, framer drives ready.
interface tx_mac_framer_if;
    import tx_mac_framer_pkg::*;

    logic [GMII_DATA_W-1:0] tx_data;
    logic                   tx_valid;
    logic                   tx_last;
    logic                   tx_ready;

    modport master (output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/tx_mac_framer_crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32; also used by the RX FCS check.
module crc32_d8
    import tx_mac_framer_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        crc_next = c;
    end
endmodule

// File: rtl/tx_mac_framer.sv
// GMII transmit framer: preamble/SFD, frame bytes, zero pad, CRC-32 FCS, enforced IFG.
// Every GMII output is registered; a byte accepted in cycle N is on gmii_txd_o in N+1.
module tx_mac_framer
    import tx_mac_framer_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int IFG_BYTES       = 12,
    parameter bit PAD_EN          = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    tx_mac_framer_if.slave         tx,
    output logic [GMII_DATA_W-1:0] gmii_txd_o,
    output logic                   gmii_tx_en_o,
    output logic                   gmii_tx_er_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   underrun_o,
    output logic                   oversize_o
);
    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int IFG_W = $clog2(IFG_BYTES + 1);

    tx_mac_state_t          state;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [IFG_W-1:0]       ifg_cnt;
    logic [IFG_W-1:0]       ifg_inc;
    logic                   ifg_last;
    logic [2:0]             sub_cnt;    // preamble byte count, then FCS byte index
    logic                   drain_er;   // first DRAIN cycle still owes the tx_er marker
    logic [31:0]            crc;
    logic [31:0]            crc_next;
    logic [31:0]            fcs_word;
    logic [7:0]             fcs_byte;
    logic [GMII_DATA_W-1:0] crc_byte;

    assign tx.tx_ready = (state == ST_SFD) || (state == ST_DATA) || (state == ST_DRAIN);
    assign busy_o      = (state != ST_IDLE);

    assign cnt_inc  = byte_cnt + CNT_W'(1);
    // IFG count saturates so a long drain cannot wrap it
    assign ifg_inc  = (ifg_cnt == IFG_W'(IFG_BYTES)) ? ifg_cnt : ifg_cnt + IFG_W'(1);
    assign ifg_last = (ifg_inc == IFG_W'(IFG_BYTES));
    assign crc_byte = (state == ST_PAD) ? '0 : tx.tx_data;
    assign fcs_word = ~crc;
    assign fcs_byte = fcs_word[{sub_cnt[1:0], 3'b000} +: 8];

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            ifg_cnt      <= '0;
            sub_cnt      <= '0;
            drain_er     <= 1'b0;
            crc          <= CRC32_INIT;
            gmii_txd_o   <= '0;
            gmii_tx_en_o <= 1'b0;
            gmii_tx_er_o <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
            oversize_o   <= 1'b0;
        end else begin
            gmii_tx_er_o <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
            oversize_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gmii_txd_o   <= '0;
                    gmii_tx_en_o <= 1'b0;
                    crc          <= CRC32_INIT;
                    byte_cnt     <= '0;
                    ifg_cnt      <= '0;
                    if (tx.tx_valid) begin
                        gmii_txd_o   <= PREAMBLE_BYTE;
                        gmii_tx_en_o <= 1'b1;
                        sub_cnt      <= 3'd1;
                        state        <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (sub_cnt == 3'(PREAMBLE_LEN)) begin
                        gmii_txd_o <= SFD_BYTE;
                        state      <= ST_SFD;
                    end else begin
                        gmii_txd_o <= PREAMBLE_BYTE;
                        sub_cnt    <= sub_cnt + 3'd1;
                    end
                end
                // SFD is on the wire here, so the first data byte is taken in this cycle
                ST_SFD, ST_DATA: begin
                    if (tx.tx_valid) begin
                        gmii_txd_o <= tx.tx_data;
                        crc        <= crc_next;
                        byte_cnt   <= cnt_inc;
                        if (tx.tx_last) begin
                            sub_cnt <= '0;
                            state   <= (PAD_EN && (cnt_inc < CNT_W'(MIN_FRAME_BYTES))) ? ST_PAD : ST_FCS;
                        end else if (cnt_inc == CNT_W'(MAX_FRAME_BYTES)) begin
                            drain_er <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        gmii_txd_o   <= '0;
                        gmii_tx_er_o <= 1'b1;
                        underrun_o   <= 1'b1;
                        state        <= ST_ABORT;
                    end
                end
                ST_PAD: begin
                    gmii_txd_o <= '0;
                    crc        <= crc_next;
                    byte_cnt   <= cnt_inc;
                    if (cnt_inc == CNT_W'(MIN_FRAME_BYTES))
                        state <= ST_FCS;
                end
                ST_FCS: begin
                    gmii_txd_o <= fcs_byte;
                    sub_cnt    <= sub_cnt + 3'd1;
                    if (sub_cnt == 3'd3) begin
                        frame_done_o <= 1'b1;
                        state        <= ST_IFG;
                    end
                end
                ST_ABORT: begin
                    gmii_txd_o   <= '0;
                    gmii_tx_en_o <= 1'b0;
                    ifg_cnt      <= ifg_inc;
                    state        <= ST_IFG;
                end
                // Entered while the final tx_en byte is still on the wire
                ST_IFG: begin
                    gmii_txd_o   <= '0;
                    gmii_tx_en_o <= 1'b0;
                    ifg_cnt      <= ifg_inc;
                    if (ifg_last)
                        state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    gmii_txd_o <= '0;
                    drain_er   <= 1'b0;
                    if (drain_er) begin
                        gmii_tx_er_o <= 1'b1;
                        oversize_o   <= 1'b1;
                    end else begin
                        gmii_tx_en_o <= 1'b0;
                        ifg_cnt      <= ifg_inc;
                    end
                    if (tx.tx_valid && tx.tx_last)
                        state <= ST_IFG;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_mac_framer.sv
// Directed bench: one unpadded framer and one padded framer with MAX_FRAME_BYTES=64 share the stimulus.
module tb_tx_mac_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] s_data;
    logic       s_valid, s_last, sel;

    tx_mac_framer_if ifa ();
    tx_mac_framer_if ifb ();
    assign ifa.tx_data  = s_data;
    assign ifa.tx_valid = s_valid;
    assign ifa.tx_last  = s_last;
    assign ifb.tx_data  = s_data;
    assign ifb.tx_valid = s_valid;
    assign ifb.tx_last  = s_last;

    logic [7:0] txd_a, txd_b;
    logic en_a, er_a, busy_a, done_a, und_a, ovr_a;
    logic en_b, er_b, busy_b, done_b, und_b, ovr_b;

    tx_mac_framer #(.PAD_EN(1'b0)) u_nopad (
        .clk(clk), .rst(rst), .tx(ifa),
        .gmii_txd_o(txd_a), .gmii_tx_en_o(en_a), .gmii_tx_er_o(er_a), .busy_o(busy_a),
        .frame_done_o(done_a), .underrun_o(und_a), .oversize_o(ovr_a)
    );

    tx_mac_framer #(.PAD_EN(1'b1), .MAX_FRAME_BYTES(64)) u_pad (
        .clk(clk), .rst(rst), .tx(ifb),
        .gmii_txd_o(txd_b), .gmii_tx_en_o(en_b), .gmii_tx_er_o(er_b), .busy_o(busy_b),
        .frame_done_o(done_b), .underrun_o(und_b), .oversize_o(ovr_b)
    );

    wire [7:0] o_txd   = sel ? txd_b  : txd_a;
    wire       o_en    = sel ? en_b   : en_a;
    wire       o_er    = sel ? er_b   : er_a;
    wire       o_busy  = sel ? busy_b : busy_a;
    wire       o_done  = sel ? done_b : done_a;
    wire       o_under = sel ? und_b  : und_a;
    wire       o_over  = sel ? ovr_b  : ovr_a;
    wire       s_ready = sel ? ifb.tx_ready : ifa.tx_ready;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every tx_en byte plus event counters, sampled on the falling edge
    logic [7:0] cap[$];
    int  er_cnt = 0, done_cnt = 0, under_cnt = 0, over_cnt = 0;
    int  gap_run = 0, last_gap = 0, under_pos = 0, over_pos = 0;
    bit  seen_en = 1'b0;
    logic [7:0] done_byte = 8'h00;

    always @(negedge clk) begin
        if (o_en) begin
            cap.push_back(o_txd);
            if (seen_en && gap_run > 0) last_gap = gap_run;
            gap_run = 0;
            seen_en = 1'b1;
        end else begin
            gap_run++;
        end
        if (o_er) er_cnt++;
        if (o_done) begin done_cnt++; done_byte = o_txd; end
        if (o_under) begin under_cnt++; under_pos = cap.size(); end
        if (o_over) begin over_cnt++; over_pos = cap.size(); end
    end

    logic [7:0] fb [0:127];
    int c0, er0, d0, u0, ov0;

    task automatic snap();
        c0 = cap.size(); er0 = er_cnt; d0 = done_cnt; u0 = under_cnt; ov0 = over_cnt;
    endtask

    // Drive fb[0..n-1]; drop_at>0 deasserts valid right after that many bytes are taken
    task automatic send(input int n, input int drop_at);
        int acc = 0;
        int guard = 0;
        bit hs;
        s_valid = 1'b1; s_data = fb[0]; s_last = (n == 1);
        while (acc < n && !(drop_at != 0 && acc == drop_at) && guard < 4000) begin
            @(negedge clk); hs = s_ready;
            @(posedge clk); #1; guard++;
            if (hs) begin
                acc++;
                if (acc < n) begin s_data = fb[acc]; s_last = (acc == n - 1); end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("accepted", acc, (drop_at != 0) ? drop_at : n);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (o_busy && n < max_cyc) begin @(negedge clk); n++; end
        chk("idle", {31'h0, o_busy}, 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] residue(input int from, input int to);
        logic [31:0] r = 32'hFFFF_FFFF;
        for (int i = from; i < to; i++) begin
            r = r ^ {24'h0, cap[i]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_fcs [0:3];
        int nz;
        exp_fcs[0] = 8'h26; exp_fcs[1] = 8'h39; exp_fcs[2] = 8'hF4; exp_fcs[3] = 8'hCB;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_en", {31'h0, o_en}, 0);
        chk("rst_txd", {24'h0, o_txd}, 0);
        chk("rst_busy", {31'h0, o_busy}, 0);
        chk("rst_ready", {31'h0, s_ready}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // "123456789", no pad
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        snap(); send(9, 0); wait_idle(200);
        chk("t1_len", cap.size() - c0, 21);
        for (int i = 0; i < 7; i++) chk("t1_pre", {24'h0, cap[c0 + i]}, 32'h55);
        chk("t1_sfd", {24'h0, cap[c0 + 7]}, 32'hD5);
        for (int i = 0; i < 9; i++) chk("t1_data", {24'h0, cap[c0 + 8 + i]}, 32'h31 + i);
        for (int i = 0; i < 4; i++) chk("t1_fcs", {24'h0, cap[c0 + 17 + i]}, {24'h0, exp_fcs[i]});
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_done_byte", {24'h0, done_byte}, 32'hCB);
        chk("t1_er", er_cnt - er0, 0);

        // single-byte frame, no pad
        fb[0] = 8'hA5;
        snap(); send(1, 0); wait_idle(200);
        chk("t1b_len", cap.size() - c0, 13);
        chk("t1b_data", {24'h0, cap[c0 + 8]}, 32'hA5);
        chk("t1b_residue", residue(c0 + 8, c0 + 13), 32'hDEBB_20E3);

        sel = 1'b1;
        wait_idle(400);

        // 14-byte frame padded to 60
        for (int i = 0; i < 14; i++) fb[i] = 8'h01 + 8'(i);
        snap(); send(14, 0); wait_idle(400);
        chk("t2_len", cap.size() - c0, 72);
        chk("t2_pre", {24'h0, cap[c0]}, 32'h55);
        chk("t2_sfd", {24'h0, cap[c0 + 7]}, 32'hD5);
        chk("t2_first", {24'h0, cap[c0 + 8]}, 32'h01);
        chk("t2_lastdata", {24'h0, cap[c0 + 21]}, 32'h0E);
        nz = 0;
        for (int i = 22; i < 68; i++) if (cap[c0 + i] != 8'h00) nz++;
        chk("t2_pad_nonzero", nz, 0);
        chk("t2_residue", residue(c0 + 8, c0 + 72), 32'hDEBB_20E3);
        chk("t2_done", done_cnt - d0, 1);

        // back-to-back with valid held high
        snap(); send(14, 0); send(14, 0); wait_idle(400);
        chk("t3_len", cap.size() - c0, 144);
        chk("t3_gap", last_gap, 12);
        chk("t3_done", done_cnt - d0, 2);
        chk("t3_pre2", {24'h0, cap[c0 + 72]}, 32'h55);

        // underrun after byte 20, then recovery frame
        for (int i = 0; i < 30; i++) fb[i] = 8'h40 + 8'(i);
        snap(); send(30, 20);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        send(9, 0); wait_idle(400);
        chk("t4_len", cap.size() - c0, 101);
        chk("t4_byte20", {24'h0, cap[c0 + 27]}, 32'h53);
        chk("t4_abort_byte", {24'h0, cap[c0 + 28]}, 32'h00);
        chk("t4_under", under_cnt - u0, 1);
        chk("t4_under_pos", under_pos - c0, 29);
        chk("t4_er", er_cnt - er0, 1);
        chk("t4_gap", last_gap, 12);
        chk("t4_recover_pre", {24'h0, cap[c0 + 29]}, 32'h55);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_residue", residue(c0 + 37, c0 + 101), 32'hDEBB_20E3);

        // 100-byte frame against MAX_FRAME_BYTES=64
        for (int i = 0; i < 100; i++) fb[i] = 8'(i);
        snap(); send(100, 0); wait_idle(400);
        chk("t5_len", cap.size() - c0, 73);
        chk("t5_byte64", {24'h0, cap[c0 + 71]}, 32'h3F);
        chk("t5_er_byte", {24'h0, cap[c0 + 72]}, 32'h00);
        chk("t5_over", over_cnt - ov0, 1);
        chk("t5_over_pos", over_pos - c0, 73);
        chk("t5_er", er_cnt - er0, 1);
        chk("t5_done", done_cnt - d0, 0);

        // reset while padding
        for (int i = 0; i < 14; i++) fb[i] = 8'h01 + 8'(i);
        send(14, 0);
        repeat (5) @(posedge clk); #1;
        chk("t6_pre_rst_en", {31'h0, o_en}, 1);
        rst = 1'b1; #1;
        chk("t6_rst_en", {31'h0, o_en}, 0);
        chk("t6_rst_txd", {24'h0, o_txd}, 0);
        chk("t6_rst_busy", {31'h0, o_busy}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        snap(); send(9, 0); wait_idle(400);
        chk("t6_len", cap.size() - c0, 72);
        chk("t6_pre", {24'h0, cap[c0]}, 32'h55);
        chk("t6_sfd", {24'h0, cap[c0 + 7]}, 32'hD5);
        chk("t6_residue", residue(c0 + 8, c0 + 72), 32'hDEBB_20E3);
        chk("t6_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
